// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the pin input conditioner: FSM state encoding
// and the saturating increment used by the statistics counters.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } cond_state_e;

  // Counters up to this width are handled by sat_inc; callers zero-extend
  // their value and pass their own all-ones ceiling.
  localparam int SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] value,
    input logic [SAT_W-1:0] max_value
  );
    if (value >= max_value) begin
      return value;
    end
    return value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit; q is the
// last flop of a STAGES-deep shift chain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Conditions an asynchronous pin into a debounced level with one-cycle edge
// pulses, and keeps saturating counts of accepted edges and rejected glitches.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin_in,
  input  logic             enable,
  input  logic             clr_cnt,
  output logic             out_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int                DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]     CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SAT_W-1:0]  CNT_MAX  = SAT_W'({CNT_W{1'b1}});

  logic        sync;
  cond_state_e state, state_n;
  logic [DW-1:0] deb_cnt, deb_cnt_n;
  logic        rise_n, fall_n;
  logic        edge_inc, glitch_inc;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pin_in),
    .q    (sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOW;
      deb_cnt    <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      deb_cnt    <= deb_cnt_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive agreeing
  // samples; any disagreement while pending falls back and counts a glitch.
  always_comb begin
    state_n    = state;
    deb_cnt_n  = deb_cnt;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    edge_inc   = 1'b0;
    glitch_inc = 1'b0;

    if (!enable) begin
      deb_cnt_n = '0;
      case (state)
        PEND_HIGH: state_n = ST_LOW;
        PEND_LOW:  state_n = ST_HIGH;
        default:   state_n = state;
      endcase
    end else begin
      case (state)
        ST_LOW: begin
          if (sync) begin
            state_n   = PEND_HIGH;
            deb_cnt_n = DW'(1);
          end else begin
            deb_cnt_n = '0;
          end
        end
        PEND_HIGH: begin
          if (!sync) begin
            state_n    = ST_LOW;
            deb_cnt_n  = '0;
            glitch_inc = 1'b1;
          end else if (deb_cnt == CNT_LAST) begin
            state_n   = ST_HIGH;
            deb_cnt_n = '0;
            rise_n    = 1'b1;
            edge_inc  = 1'b1;
          end else begin
            deb_cnt_n = deb_cnt + DW'(1);
          end
        end
        ST_HIGH: begin
          if (!sync) begin
            state_n   = PEND_LOW;
            deb_cnt_n = DW'(1);
          end else begin
            deb_cnt_n = '0;
          end
        end
        PEND_LOW: begin
          if (sync) begin
            state_n    = ST_HIGH;
            deb_cnt_n  = '0;
            glitch_inc = 1'b1;
          end else if (deb_cnt == CNT_LAST) begin
            state_n   = ST_LOW;
            deb_cnt_n = '0;
            fall_n    = 1'b1;
            edge_inc  = 1'b1;
          end else begin
            deb_cnt_n = deb_cnt + DW'(1);
          end
        end
        default: begin
          state_n   = ST_LOW;
          deb_cnt_n = '0;
        end
      endcase
    end
  end

  // The level is implied by the state: PEND_LOW still reports the old high.
  assign out_level = (state == ST_HIGH) || (state == PEND_LOW);

  // A clear in the same cycle as an event wins and that event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt   <= '0;
      glitch_cnt <= '0;
    end else if (clr_cnt) begin
      edge_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      if (edge_inc) begin
        edge_cnt <= CNT_W'(sat_inc(SAT_W'(edge_cnt), CNT_MAX));
      end
      if (glitch_inc) begin
        glitch_cnt <= CNT_W'(sat_inc(SAT_W'(glitch_cnt), CNT_MAX));
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: default build, a 2-bit counter build
// and a short-debounce / deep-synchroniser build, each with its own stimulus.
module tb_input_conditioner;

  logic clk;

  logic       rst0, pin0, en0, clr0;
  logic       lvl0, rise0, fall0;
  logic [7:0] ecnt0, gcnt0;

  logic       rst1, pin1, en1, clr1;
  logic       lvl1, rise1, fall1;
  logic [1:0] ecnt1, gcnt1;

  logic       rst2, pin2, en2, clr2;
  logic       lvl2, rise2, fall2;
  logic [7:0] ecnt2, gcnt2;

  int checks;
  int errors;

  input_conditioner dut0 (
    .clk(clk), .reset(rst0), .pin_in(pin0), .enable(en0), .clr_cnt(clr0),
    .out_level(lvl0), .rise_pulse(rise0), .fall_pulse(fall0),
    .edge_cnt(ecnt0), .glitch_cnt(gcnt0)
  );

  input_conditioner #(.CNT_W(2)) dut1 (
    .clk(clk), .reset(rst1), .pin_in(pin1), .enable(en1), .clr_cnt(clr1),
    .out_level(lvl1), .rise_pulse(rise1), .fall_pulse(fall1),
    .edge_cnt(ecnt1), .glitch_cnt(gcnt1)
  );

  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst2), .pin_in(pin2), .enable(en2), .clr_cnt(clr2),
    .out_level(lvl2), .rise_pulse(rise2), .fall_pulse(fall2),
    .edge_cnt(ecnt2), .glitch_cnt(gcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; pin0 = 1'b0; en0 = 1'b1; clr0 = 1'b0;
    tick(); tick();
    checks++;
    if ({lvl0, rise0, fall0} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_outputs got %b expected 000", {lvl0, rise0, fall0});
    end
    checks++;
    if ((ecnt0 !== 8'd0) || (gcnt0 !== 8'd0)) begin
      errors++; $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", ecnt0, gcnt0);
    end
    rst0 = 1'b0;
  endtask

  task automatic test_rise();
    logic early;
    early = 1'b0;
    pin0 = 1'b1;
    repeat (5) begin
      tick();
      if (lvl0 || rise0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("[TB] FAIL rise_latency_early got %b expected 0", early);
    end
    tick();
    checks++;
    if ({lvl0, rise0} !== 2'b11) begin
      errors++; $display("[TB] FAIL rise_edge6 got %b expected 11", {lvl0, rise0});
    end
    checks++;
    if (ecnt0 !== 8'd1) begin
      errors++; $display("[TB] FAIL rise_edge_cnt got %0d expected 1", ecnt0);
    end
    tick();
    checks++;
    if ({lvl0, rise0, fall0} !== 3'b100) begin
      errors++; $display("[TB] FAIL rise_one_cycle got %b expected 100", {lvl0, rise0, fall0});
    end
    repeat (4) tick();
    checks++;
    if ((ecnt0 !== 8'd1) || (lvl0 !== 1'b1)) begin
      errors++; $display("[TB] FAIL rise_hold got cnt %0d lvl %b expected 1 1", ecnt0, lvl0);
    end
  endtask

  task automatic test_fall();
    pin0 = 1'b0;
    repeat (5) tick();
    checks++;
    if (lvl0 !== 1'b1) begin
      errors++; $display("[TB] FAIL fall_latency_early got %b expected 1", lvl0);
    end
    tick();
    checks++;
    if ({lvl0, fall0, rise0} !== 3'b010 || ecnt0 !== 8'd2) begin
      errors++; $display("[TB] FAIL fall_edge6 got lvl/fall/rise %b cnt %0d expected 010 2",
                         {lvl0, fall0, rise0}, ecnt0);
    end
    tick();
    checks++;
    if (fall0 !== 1'b0) begin
      errors++; $display("[TB] FAIL fall_one_cycle got %b expected 0", fall0);
    end
  endtask

  task automatic test_glitch();
    logic bad;
    for (int i = 0; i < 3; i++) begin
      bad = 1'b0;
      pin0 = 1'b1;
      tick(); tick();
      pin0 = 1'b0;
      repeat (6) begin
        tick();
        if (lvl0 || rise0 || fall0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
        errors++; $display("[TB] FAIL glitch_no_output iter %0d got %b expected 0", i, bad);
      end
      checks++;
      if (gcnt0 !== 8'(i + 1)) begin
        errors++; $display("[TB] FAIL glitch_cnt iter %0d got %0d expected %0d", i, gcnt0, i + 1);
      end
    end
    checks++;
    if (ecnt0 !== 8'd2) begin
      errors++; $display("[TB] FAIL glitch_edge_cnt got %0d expected 2", ecnt0);
    end
  endtask

  task automatic test_enable();
    pin0 = 1'b1;
    repeat (4) tick();
    en0 = 1'b0;
    repeat (3) tick();
    checks++;
    if ((lvl0 !== 1'b0) || (gcnt0 !== 8'd3) || (rise0 !== 1'b0)) begin
      errors++; $display("[TB] FAIL enable_freeze got lvl %b glitch %0d rise %b expected 0 3 0",
                         lvl0, gcnt0, rise0);
    end
    en0 = 1'b1;
    repeat (3) tick();
    checks++;
    if (lvl0 !== 1'b0) begin
      errors++; $display("[TB] FAIL enable_resume_early got %b expected 0", lvl0);
    end
    tick();
    checks++;
    if ({lvl0, rise0} !== 2'b11 || ecnt0 !== 8'd3) begin
      errors++; $display("[TB] FAIL enable_resume got lvl/rise %b cnt %0d expected 11 3",
                         {lvl0, rise0}, ecnt0);
    end
  endtask

  task automatic test_reset_mid_pend();
    logic bad;
    bad = 1'b0;
    pin0 = 1'b0;
    repeat (4) tick();
    checks++;
    if (lvl0 !== 1'b1) begin
      errors++; $display("[TB] FAIL pend_low_level got %b expected 1", lvl0);
    end
    rst0 = 1'b1;
    #1;
    checks++;
    if ({lvl0, fall0} !== 2'b00 || ecnt0 !== 8'd0 || gcnt0 !== 8'd0) begin
      errors++; $display("[TB] FAIL async_reset got lvl/fall %b cnt %0d/%0d expected 00 0/0",
                         {lvl0, fall0}, ecnt0, gcnt0);
    end
    tick();
    rst0 = 1'b0;
    repeat (8) begin
      tick();
      if (fall0 || lvl0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_no_fall got %b expected 0", bad);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    rst1 = 1'b1; pin1 = 1'b0; en1 = 1'b1; clr1 = 1'b0;
    tick(); tick();
    rst1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      pin1 = (i % 2 == 1) ? 1'b1 : 1'b0;
      repeat (8) tick();
      exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
      checks++;
      if (ecnt1 !== exp_cnt) begin
        errors++; $display("[TB] FAIL sat_edge_cnt after %0d got %0d expected %0d", i, ecnt1, exp_cnt);
      end
    end
    pin1 = 1'b0;
    repeat (5) tick();
    clr1 = 1'b1;
    tick();
    checks++;
    if (fall1 !== 1'b1 || ecnt1 !== 2'd0) begin
      errors++; $display("[TB] FAIL clr_with_edge got fall %b cnt %0d expected 1 0", fall1, ecnt1);
    end
    clr1 = 1'b0;
    tick();
    checks++;
    if (ecnt1 !== 2'd0 || lvl1 !== 1'b0 || gcnt1 !== 2'd0) begin
      errors++; $display("[TB] FAIL clr_after got cnt %0d lvl %b glitch %0d expected 0 0 0",
                         ecnt1, lvl1, gcnt1);
    end
  endtask

  task automatic test_short_debounce();
    int rise_n, fall_n, rise_at, fall_at;
    logic both;
    rise_n = 0; fall_n = 0; rise_at = 0; fall_at = 0; both = 1'b0;
    rst2 = 1'b1; pin2 = 1'b0; en2 = 1'b1; clr2 = 1'b0;
    tick(); tick();
    rst2 = 1'b0;
    pin2 = 1'b1;
    tick();
    pin2 = 1'b0;
    repeat (8) tick();
    checks++;
    if (gcnt2 !== 8'd1 || lvl2 !== 1'b0 || ecnt2 !== 8'd0) begin
      errors++; $display("[TB] FAIL short_glitch got glitch %0d lvl %b edge %0d expected 1 0 0",
                         gcnt2, lvl2, ecnt2);
    end
    pin2 = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) pin2 = 1'b0;
      tick();
      if (rise2) begin rise_n++; rise_at = t; end
      if (fall2) begin fall_n++; fall_at = t; end
      if (rise2 && fall2) both = 1'b1;
    end
    checks++;
    if (rise_n != 1 || rise_at != 5) begin
      errors++; $display("[TB] FAIL short_rise got %0d pulses at %0d expected 1 at 5", rise_n, rise_at);
    end
    checks++;
    if (fall_n != 1 || fall_at != 8) begin
      errors++; $display("[TB] FAIL short_fall got %0d pulses at %0d expected 1 at 8", fall_n, fall_at);
    end
    checks++;
    if (ecnt2 !== 8'd2 || both !== 1'b0 || gcnt2 !== 8'd1) begin
      errors++; $display("[TB] FAIL short_counts got edge %0d both %b glitch %0d expected 2 0 1",
                         ecnt2, both, gcnt2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1; pin0 = 1'b0; en0 = 1'b1; clr0 = 1'b0;
    rst1 = 1'b1; pin1 = 1'b0; en1 = 1'b1; clr1 = 1'b0;
    rst2 = 1'b1; pin2 = 1'b0; en2 = 1'b1; clr2 = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_enable();
    test_reset_mid_pend();
    test_saturation();
    test_short_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
